// File: rtl/led_spi_rx.sv
// SPI responder for the LED-array link: oversamples load/clk/data on i_clk,
// shifts in command frames and decodes them into a MAX7219-style register file.
module led_spi_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_spi_clk,
   input  logic        i_spi_load,
   input  logic        i_spi_data,
   output logic        o_spi_dout,
   output logic [63:0] o_display,
   output logic [7:0]  o_decode,
   output logic [3:0]  o_intensity,
   output logic [2:0]  o_scan_limit,
   output logic        o_shutdown_n,
   output logic        o_test,
   output logic        o_frame_valid,
   output logic [3:0]  o_frame_addr,
   output logic [7:0]  o_frame_data,
   output logic        o_frame_err
);

   localparam int          SL      = SYNC_STAGES;
   localparam logic [4:0]  CNT_MAX = 5'd31;
   localparam logic [4:0]  CNT_EXP = 5'(FRAME_BITS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [SL:0]             r_sclk_sh;
   logic [SL:0]             r_load_sh;
   logic [SL:0]             r_data_sh;
   logic [FRAME_BITS-1:0]   r_sr;
   logic [4:0]              r_cnt;
   logic [7:0]              r_decode;
   logic [3:0]              r_intensity;
   logic [2:0]              r_scan_limit;
   logic                    r_shutdown_n;
   logic                    r_test;
   logic                    r_valid;
   logic                    r_err;
   logic [3:0]              r_addr;
   logic [7:0]              r_fdata;

   logic                    w_sclk_rise;
   logic                    w_load_rise;
   logic                    w_load_fall;
   logic                    w_sdata;
   logic                    w_shift;
   logic                    w_latch;
   logic                    w_cnt_ok;
   logic                    w_accept;
   logic                    w_reject;
   logic [3:0]              w_addr;
   logic [7:0]              w_fbyte;

   // Load chain idles high so releasing reset with load deasserted is not seen as a load rise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_sh <= '0;
         r_load_sh <= '1;
         r_data_sh <= '0;
      end else begin
         r_sclk_sh <= {r_sclk_sh[SL-1:0], i_spi_clk};
         r_load_sh <= {r_load_sh[SL-1:0], i_spi_load};
         r_data_sh <= {r_data_sh[SL-1:0], i_spi_data};
      end
   end

   assign w_sclk_rise = r_sclk_sh[SL-1] & ~r_sclk_sh[SL];
   assign w_load_rise = r_load_sh[SL-1] & ~r_load_sh[SL];
   assign w_load_fall = ~r_load_sh[SL-1] & r_load_sh[SL];
   assign w_sdata     = r_data_sh[SL];
   // Gating on the previous load level lets a clock rise coincident with load rise still shift.
   assign w_shift     = w_sclk_rise & ~r_load_sh[SL];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_latch      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_load_rise) begin
               w_state_next = ST_LATCH;
            end else if (w_load_fall) begin
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_load_rise) begin
               w_state_next = ST_LATCH;
            end
         end
         ST_LATCH: begin
            w_latch      = 1'b1;
            w_state_next = w_load_fall ? ST_SHIFT : ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_cnt_ok = (r_cnt == CNT_EXP);
   assign w_accept = w_latch & w_cnt_ok;
   assign w_reject = w_latch & ~w_cnt_ok;
   assign w_addr   = r_sr[11:8];
   assign w_fbyte  = r_sr[7:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_shift) begin
            r_sr <= {r_sr[FRAME_BITS-2:0], w_sdata};
         end
         if (w_latch || w_load_fall) begin
            r_cnt <= '0;
         end else if (w_shift && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 5'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid      <= 1'b0;
         r_err        <= 1'b0;
         r_addr       <= '0;
         r_fdata      <= '0;
         r_decode     <= '0;
         r_intensity  <= '0;
         r_scan_limit <= '0;
         r_shutdown_n <= 1'b0;
         r_test       <= 1'b0;
      end else begin
         r_valid <= w_accept;
         r_err   <= w_reject;
         if (w_accept) begin
            r_addr  <= w_addr;
            r_fdata <= w_fbyte;
            case (w_addr)
               4'h9:    r_decode     <= w_fbyte;
               4'hA:    r_intensity  <= w_fbyte[3:0];
               4'hB:    r_scan_limit <= w_fbyte[2:0];
               4'hC:    r_shutdown_n <= w_fbyte[0];
               4'hF:    r_test       <= w_fbyte[0];
               default: ;
            endcase
         end
      end
   end

   // Digit rows live at addresses 1..8; row r occupies o_display[8r-1:8r-8].
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_row
         logic [7:0] r_row;
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_row <= '0;
            end else if (w_accept && (w_addr == 4'(gi + 1))) begin
               r_row <= w_fbyte;
            end
         end
         assign o_display[8*gi +: 8] = r_row;
      end
   endgenerate

   assign o_spi_dout    = r_sr[FRAME_BITS-1];
   assign o_decode      = r_decode;
   assign o_intensity   = r_intensity;
   assign o_scan_limit  = r_scan_limit;
   assign o_shutdown_n  = r_shutdown_n;
   assign o_test        = r_test;
   assign o_frame_valid = r_valid;
   assign o_frame_addr  = r_addr;
   assign o_frame_data  = r_fdata;
   assign o_frame_err   = r_err;

endmodule

// File: doc/led_spi_rx.md
# led_spi_rx

Behavioural-grade SPI responder for the LED-array link: the receiving end of the serial load/data/clock interface that the UART-to-SPI bridge drives. It oversamples the three SPI lines on the system clock and shifts in 16-bit MAX7219-style command frames. On each load strobe it decodes the frame into a register file (8 digit rows, decode mode, intensity, scan limit, shutdown, display test). It is used on-board as a loopback checker and in simulation as the display model on the bridge's SPI pins.

## Interface
- SYNC_STAGES, 2, synchronizer flops per SPI input (minimum 2)
- FRAME_BITS, 16, bits per command frame (address [11:8], data [7:0], [15:12] ignored)

- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_spi_clk  in  1  SPI serial clock (asynchronous to i_clk)
- i_spi_load  in  1  SPI load/chip-select, frame latched on rising edge
- i_spi_data  in  1  SPI serial data, MSB first
- o_spi_dout  out  1  daisy-chain output, MSB of shift register
- o_display  out  64  row registers, row r (1..8) at bits [8r-1:8r-8]
- o_decode  out  8  decode-mode register
- o_intensity  out  4  intensity register
- o_scan_limit  out  3  scan-limit register
- o_shutdown_n  out  1  0 = shutdown, 1 = normal operation
- o_test  out  1  display-test register bit
- o_frame_valid  out  1  one-cycle pulse, frame accepted
- o_frame_addr  out  4  address of last accepted frame
- o_frame_data  out  8  data of last accepted frame
- o_frame_err  out  1  one-cycle pulse, frame rejected (bit count != FRAME_BITS)

## Operation
- Each SPI input passes through SYNC_STAGES flops then one history flop; rise/fall detected by comparing last two stages.
- Shift: on detected i_spi_clk rise while synchronized load is low, sr <= {sr[FRAME_BITS-2:0], data_sync}; bit counter increments, saturating at 31.
- Bits clocked while load is high are ignored (no shift, no count).
- Load fall: bit counter cleared to 0; shift register retained.
- Load rise: if count == FRAME_BITS, frame accepted: o_frame_valid pulse, o_frame_addr/o_frame_data updated, target register written; otherwise o_frame_err pulse, no register write. Counter cleared either way.
- Address decode: 0x0 no-op (valid pulse, no write); 0x1-0x8 row r; 0x9 decode; 0xA intensity <= data[3:0]; 0xB scan_limit <= data[2:0]; 0xC shutdown_n <= data[0]; 0xF test <= data[0]; 0xD/0xE accepted, no write.
- o_spi_dout = sr[FRAME_BITS-1], registered; updates on the shift cycle.
- States: IDLE (load high), SHIFT (load low, counting), LATCH (single cycle on load rise) -> IDLE.

## Timing
- All outputs reset to 0: display, decode, intensity, scan_limit, shutdown_n (display in shutdown), test, dout, frame_valid, frame_addr, frame_data, frame_err; state IDLE, counter 0, sr 0.
- Edge-to-action latency: SYNC_STAGES+1 i_clk cycles from pin edge to shift/latch cycle (3 with default); registers and pulses visible the cycle after.
- Required SPI timing: clk high and low each >= 4 i_clk periods; data stable 4 i_clk periods around clk rise; load rise >= 4 i_clk after last clk rise.
- Clock rise and load rise detected in same cycle: shift first, then evaluate count including that bit (LATCH the following cycle).
- Back-to-back frames: load low again immediately after LATCH is legal; no frame lost.
- Reset asserted mid-frame: immediate clear of all state/outputs; partial frame discarded; after release, first load rise without a full frame gives o_frame_err.
- frame_valid and frame_err never high in the same cycle.

## Test plan
- Reset: hold i_rst_n low 5 cycles -> all outputs 0, o_shutdown_n = 0.
- Frame 0x0C01 at 5 MHz SPI/100 MHz clk -> one o_frame_valid, addr 0xC, data 0x01, o_shutdown_n = 1.
- Frames 0x0181 then 0x08FF back-to-back -> o_display[7:0] = 0x81, o_display[63:56] = 0xFF, two valid pulses, other rows 0.
- 15-bit frame and 17-bit frame with addr 0xA -> two o_frame_err pulses, o_intensity unchanged at 0.
- Frame 0x0A07 with last clk rise coinciding with load rise -> accepted, o_intensity = 7; o_spi_dout follows shifted MSB sequence.
- Reset asserted after 8 bits of 0x0B05, then full 0x0B05 -> o_scan_limit stays 0 then becomes 5, exactly one valid pulse.
